sdf_stage8: RTL and testbench

SDF_STAGE8 -- requirements
Module: sdf_stage8

---
 rtl/sdf_stage8.sv | 216 +++++++++++++++++++++
 tb/tb_sdf_stage8.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage8.sv
// ----------------------------------------------------------------------------
// sdf_stage8 : radix-2 single-path delay-feedback FFT stage, 16-sample frames.
//   An 8-deep complex delay line feeds a butterfly. Sums go straight out, and
//   differences are fed back, then leave multiplied by W16^n.
//
// Ports
//   clk        : rising-edge clock for all state
//   rst_n      : asynchronous active-low reset
//   valid_i    : frame-start qualifier, sampled only when a frame may begin
//   data_in_r  : signed 14-bit real input sample, one per cycle inside a frame
//   data_in_i  : signed 14-bit imaginary input sample
//   valid_o    : data_out_r/data_out_i carry a stage result
//   data_out_r : registered signed 14-bit real result (0 when valid_o=0)
//   data_out_i : registered signed 14-bit imaginary result (0 when valid_o=0)
//   state      : current FSM state, IDLE=00 FILL=01 BFLY=10 TWID=11
// ----------------------------------------------------------------------------
module sdf_stage8 (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_i,
   input  logic signed [13:0] data_in_r,
   input  logic signed [13:0] data_in_i,
   output logic               valid_o,
   output logic signed [13:0] data_out_r,
   output logic signed [13:0] data_out_i,
   output logic [1:0]         state
);

   localparam int unsigned DW    = 14;  // sample width
   localparam int unsigned SW    = 15;  // butterfly sum/difference width
   localparam int unsigned TW    = 8;   // twiddle width, Q1.6
   localparam int unsigned PW    = 23;  // complex product width
   localparam int unsigned DEPTH = 8;   // delay-line depth

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_FILL = 2'b01,
      S_BFLY = 2'b10,
      S_TWID = 2'b11
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt;
   logic                  acc_q;    // next frame was accepted at TWID n=0
   logic signed [DW-1:0]  dl_r [DEPTH];
   logic signed [DW-1:0]  dl_i [DEPTH];

   logic signed [DW-1:0]  a_r, a_i;
   logic signed [SW-1:0]  sum_r_w, sum_i_w, dif_r_w, dif_i_w;
   logic signed [DW-1:0]  sum_r, sum_i, dif_r, dif_i;
   logic signed [TW-1:0]  w_r, w_i;
   logic signed [PW-1:0]  p_r, p_i, rnd_r, rnd_i;
   logic signed [DW-1:0]  tw_r, tw_i;
   logic                  take_c;
   logic                  sh_en;
   logic signed [DW-1:0]  sh_r, sh_i;

   assign state = state_q;

   // Clamp a 15-bit butterfly result to the 14-bit sample range.
   function automatic logic signed [13:0] sat_sum(input logic signed [14:0] v);
      if (v > 15'sd8191)       return 14'sd8191;
      else if (v < -15'sd8192) return 14'sh2000;
      else                     return v[13:0];
   endfunction

   // Clamp a rounded product to the 14-bit sample range.
   function automatic logic signed [13:0] sat_prod(input logic signed [22:0] v);
      if (v > 23'sd8191)       return 14'sd8191;
      else if (v < -23'sd8192) return 14'sh2000;
      else                     return v[13:0];
   endfunction

   // Butterfly on oldest delay-line entry and the incoming sample.
   always_comb begin
      a_r     = dl_r[DEPTH-1];
      a_i     = dl_i[DEPTH-1];
      sum_r_w = SW'(a_r) + SW'(data_in_r);
      sum_i_w = SW'(a_i) + SW'(data_in_i);
      dif_r_w = SW'(a_r) - SW'(data_in_r);
      dif_i_w = SW'(a_i) - SW'(data_in_i);
      sum_r   = sat_sum(sum_r_w);
      sum_i   = sat_sum(sum_i_w);
      dif_r   = sat_sum(dif_r_w);
      dif_i   = sat_sum(dif_i_w);
   end

   // W16^n table, indexed by the TWID counter.
   always_comb begin
      w_r = 8'sd64;
      w_i = 8'sd0;
      case (cnt[2:0])
         3'd0: begin w_r =  8'sd64; w_i =  8'sd0;  end
         3'd1: begin w_r =  8'sd59; w_i = -8'sd25; end
         3'd2: begin w_r =  8'sd45; w_i = -8'sd46; end
         3'd3: begin w_r =  8'sd24; w_i = -8'sd60; end
         3'd4: begin w_r =  8'sd0;  w_i = -8'sd64; end
         3'd5: begin w_r = -8'sd25; w_i = -8'sd60; end
         3'd6: begin w_r = -8'sd46; w_i = -8'sd46; end
         3'd7: begin w_r = -8'sd60; w_i = -8'sd25; end
         default: ;
      endcase
   end

   // Full-precision complex multiply, round half-up, saturate.
   always_comb begin
      p_r   = PW'(a_r) * PW'(w_r) - PW'(a_i) * PW'(w_i);
      p_i   = PW'(a_r) * PW'(w_i) + PW'(a_i) * PW'(w_r);
      rnd_r = (p_r + PW'(32)) >>> 6;
      rnd_i = (p_i + PW'(32)) >>> 6;
      tw_r  = sat_prod(rnd_r);
      tw_i  = sat_prod(rnd_i);
   end

   // Delay-line input select; in TWID a new frame rides in behind the differences.
   always_comb begin
      take_c = (cnt == 4'd0) ? valid_i : acc_q;
      sh_en  = 1'b0;
      sh_r   = '0;
      sh_i   = '0;
      case (state_q)
         S_IDLE: begin
            sh_en = valid_i;
            sh_r  = data_in_r;
            sh_i  = data_in_i;
         end
         S_FILL: begin
            sh_en = 1'b1;
            sh_r  = data_in_r;
            sh_i  = data_in_i;
         end
         S_BFLY: begin
            sh_en = 1'b1;
            sh_r  = dif_r;
            sh_i  = dif_i;
         end
         S_TWID: begin
            sh_en = 1'b1;
            if (take_c) begin
               sh_r = data_in_r;
               sh_i = data_in_i;
            end
         end
         default: ;
      endcase
   end

   // FSM, counter, delay line and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt        <= '0;
         acc_q      <= 1'b0;
         valid_o    <= 1'b0;
         data_out_r <= '0;
         data_out_i <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dl_r[k] <= '0;
            dl_i[k] <= '0;
         end
      end else begin
         valid_o    <= 1'b0;
         data_out_r <= '0;
         data_out_i <= '0;

         if (sh_en) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
               dl_r[k] <= dl_r[k-1];
               dl_i[k] <= dl_i[k-1];
            end
            dl_r[0] <= sh_r;
            dl_i[0] <= sh_i;
         end

         case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  cnt     <= 4'd1;
                  state_q <= S_FILL;
               end
            end
            S_FILL: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd7) state_q <= S_BFLY;
            end
            S_BFLY: begin
               valid_o    <= 1'b1;
               data_out_r <= sum_r;
               data_out_i <= sum_i;
               cnt        <= cnt + 4'd1;   // 15 wraps to 0 = TWID n=0
               if (cnt == 4'd15) state_q <= S_TWID;
            end
            S_TWID: begin
               valid_o    <= 1'b1;
               data_out_r <= tw_r;
               data_out_i <= tw_i;
               if (cnt == 4'd0) acc_q <= valid_i;
               if (cnt == 4'd7) begin
                  acc_q <= 1'b0;
                  if (take_c) begin
                     cnt     <= 4'd8;
                     state_q <= S_BFLY;
                  end else begin
                     cnt     <= 4'd0;
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdf_stage8.sv
// ----------------------------------------------------------------------------
// tb_sdf_stage8 : scoreboard bench for sdf_stage8. Stimulus pushes expected
// results (value and cycle) into a queue; a monitor pops them on valid_o.
// ----------------------------------------------------------------------------
module tb_sdf_stage8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               valid_i;
   logic signed [13:0] din_r, din_i;
   logic               valid_o;
   logic signed [13:0] dout_r, dout_i;
   logic [1:0]         state;

   always #5 clk = ~clk;

   sdf_stage8 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (valid_i),
      .data_in_r  (din_r),
      .data_in_i  (din_i),
      .valid_o    (valid_o),
      .data_out_r (dout_r),
      .data_out_i (dout_i),
      .state      (state)
   );

   typedef struct {
      int r;
      int i;
      int c;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   run_len  = 0;
   int   last_run = 0;

   int xr[16], xi[16];
   int er[16], ei[16];
   int wr_t[8] = '{64, 59, 45, 24, 0, -25, -46, -60};
   int wi_t[8] = '{0, -25, -46, -60, -64, -60, -46, -25};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 8191)  return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   // Output j of a frame: sums for j<8, twiddled differences for j>=8.
   function automatic void model(input int j, output int r, output int im);
      int n, dr, di, pr, pi;
      if (j < 8) begin
         r  = sat(xr[j] + xr[j+8]);
         im = sat(xi[j] + xi[j+8]);
      end else begin
         n  = j - 8;
         dr = sat(xr[n] - xr[n+8]);
         di = sat(xi[n] - xi[n+8]);
         pr = dr * wr_t[n] - di * wi_t[n];
         pi = dr * wi_t[n] + di * wr_t[n];
         r  = sat((pr + 32) >>> 6);
         im = sat((pi + 32) >>> 6);
      end
   endfunction

   // Monitor: compare every valid output against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            run_len = 0;
            continue;
         end
         if (valid_o === 1'b1) begin
            run_len++;
            if (sb.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_r", int'(dout_r), e.r);
               chk("out_i", int'(dout_i), e.i);
               chk("out_cycle", cyc, e.c);
            end
         end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            chk("idle_out_zero", ((dout_r == 14'sd0) && (dout_i == 14'sd0)) ? 0 : 1, 0);
         end
      end
   end

   // Drive nsamp samples of a frame; called at posedge+1.
   task automatic send_frame(input bit hand, input bit b2b, input int nsamp);
      int   c0, st;
      exp_t e;
      c0 = cyc + 1;
      for (int j = 0; j < 16; j++) begin
         if (hand) begin
            e.r = er[j];
            e.i = ei[j];
         end else begin
            model(j, e.r, e.i);
         end
         e.c = c0 + 8 + j;
         sb.push_back(e);
      end
      for (int k = 0; k < nsamp; k++) begin
         valid_i = (k == 0);
         din_r   = 14'(xr[k]);
         din_i   = 14'(xi[k]);
         @(posedge clk);
         #1;
         if (k < 7)       st = b2b ? 3 : 1;
         else if (k < 15) st = 2;
         else             st = 3;
         if (k == 0 || k == 7 || k == 15) chk("state_in_frame", int'(state), st);
      end
   endtask

   // Idle cycles with junk data; optional valid_i pulse at index pulse_at.
   task automatic idle(input int n, input int pulse_at);
      for (int k = 0; k < n; k++) begin
         valid_i = (k == pulse_at);
         din_r   = 14'(1234 + 7 * k);
         din_i   = 14'(-777 - 3 * k);
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      idle(2, -1);
   endtask

   task automatic clear_x();
      for (int k = 0; k < 16; k++) begin
         xr[k] = 0;
         xi[k] = 0;
      end
   endtask

   task automatic load_step();
      int hr[8] = '{1000, 922, 703, 375, 0, -391, -719, -937};
      int hi[8] = '{0, -391, -719, -937, -1000, -937, -719, -391};
      clear_x();
      for (int k = 0; k < 8; k++) begin
         xr[k]   = 1000;
         er[k]   = 1000;
         ei[k]   = 0;
         er[k+8] = hr[k];
         ei[k+8] = hi[k];
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      valid_i = 1'b0;
      din_r   = '0;
      din_i   = '0;
      #12;
      chk("reset_state", int'(state), 0);
      chk("reset_valid", int'(valid_o), 0);
      chk("reset_out_r", int'(dout_r), 0);
      chk("reset_out_i", int'(dout_i), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3, -1);
      chk("idle_state", int'(state), 0);

      // Step frame with hand-computed results; valid_i pulse at TWID n=3 ignored.
      load_step();
      send_frame(1'b1, 1'b0, 16);
      idle(12, 3);
      drain();
      chk("step_run_len", last_run, 16);
      chk("step_back_idle", int'(state), 0);

      // Constant 64+64j frame.
      for (int k = 0; k < 16; k++) begin
         xr[k] = 64;
         xi[k] = 64;
      end
      send_frame(1'b0, 1'b0, 16);
      drain();
      chk("const_run_len", last_run, 16);

      // Sum saturation.
      clear_x();
      xr[0] = 8000; xi[0] = -8000;
      xr[8] = 8000; xi[8] = -8000;
      send_frame(1'b0, 1'b0, 16);
      drain();

      // Twiddle of a full-scale negative imaginary difference.
      clear_x();
      xi[4] = -8192;
      send_frame(1'b0, 1'b0, 16);
      drain();

      // Difference that saturates before the twiddle.
      clear_x();
      xi[12] = -8192;
      send_frame(1'b0, 1'b0, 16);
      drain();

      // Back-to-back frames: ramp, then step.
      for (int k = 0; k < 16; k++) begin
         xr[k] = k * 300 - 2000;
         xi[k] = 1500 - k * 217;
      end
      send_frame(1'b0, 1'b0, 16);
      load_step();
      send_frame(1'b1, 1'b1, 16);
      drain();
      chk("b2b_run_len", last_run, 32);
      chk("b2b_back_idle", int'(state), 0);

      // Asynchronous reset mid-frame, then a clean frame.
      for (int k = 0; k < 16; k++) begin
         xr[k] = 5000 - k * 611;
         xi[k] = k * 400 - 3000;
      end
      send_frame(1'b0, 1'b0, 12);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_state", int'(state), 0);
      chk("midreset_valid", int'(valid_o), 0);
      chk("midreset_out_r", int'(dout_r), 0);
      chk("midreset_out_i", int'(dout_i), 0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2, -1);
      chk("post_reset_state", int'(state), 0);
      load_step();
      send_frame(1'b1, 1'b0, 16);
      drain();
      chk("post_reset_run_len", last_run, 16);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
